// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter between two byte sources feeding one 8N1/8N2 UART transmitter.
// Ready is combinational from the valids in IDLE; all serial outputs are registered.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 345,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       owner,
  output logic       frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          done_q, done_d;

  logic grant0, grant1, cnt_end;

  // On a tie the requester that did not win last time gets the line.
  assign grant0     = req0_valid & (~req1_valid | last_q);
  assign grant1     = req1_valid & (~req0_valid | ~last_q);
  assign req0_ready = (state_q == IDLE) & grant0 & ~reset;
  assign req1_ready = (state_q == IDLE) & grant1 & ~reset;
  assign cnt_end    = (cnt_q == CNT_MAX);

  // NOTE: combinational next-state logic uses blocking '=' with every output
  // defaulted first, so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    last_d  = last_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0_ready | req1_ready) begin
          state_d = START;
          shift_d = req1_ready ? req1_data : req0_data;
          owner_d = req1_ready;
          last_d  = req1_ready;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_end) begin
          cnt_d   = '0;
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            idx_d   = '0;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        // Raised one cycle early so the registered pulse lands on the last stop cycle.
        done_d = (idx_q == STOP_LAST) && (cnt_q == CNT_PRE);
        if (cnt_end) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<='; the shift register is reset
  // too because it is cheap and keeps the idle state fully defined.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      owner_q <= 1'b1;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign owner      = owner_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with one stop bit, one with two,
// both at 4 clocks per bit; sel picks which instance is driven and observed.
module tb_uart_tx_arbiter;

  logic       clk_core = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;

  logic a_r0, a_r1, a_tx, a_busy, a_owner, a_done;
  logic b_r0, b_r1, b_tx, b_busy, b_owner, b_done;
  logic a_v0, a_v1, b_v0, b_v1;

  int tests = 0;
  int errors = 0;

  always #5 clk_core = ~clk_core;

  assign a_v0 = v0 & ~sel;
  assign a_v1 = v1 & ~sel;
  assign b_v0 = v0 & sel;
  assign b_v1 = v1 & sel;

  uart_tx_arbiter #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .clk_core(clk_core), .reset(reset),
    .req0_valid(a_v0), .req0_data(d0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_data(d1), .req1_ready(a_r1),
    .tx(a_tx), .busy(a_busy), .owner(a_owner), .frame_done(a_done)
  );

  uart_tx_arbiter #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk_core(clk_core), .reset(reset),
    .req0_valid(b_v0), .req0_data(d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_data(d1), .req1_ready(b_r1),
    .tx(b_tx), .busy(b_busy), .owner(b_owner), .frame_done(b_done)
  );

  logic r0_s, r1_s, tx_s, busy_s, owner_s, done_s;
  assign r0_s    = sel ? b_r0    : a_r0;
  assign r1_s    = sel ? b_r1    : a_r1;
  assign tx_s    = sel ? b_tx    : a_tx;
  assign busy_s  = sel ? b_busy  : a_busy;
  assign owner_s = sel ? b_owner : a_owner;
  assign done_s  = sel ? b_done  : a_done;

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the transfer cycle T; walks the whole frame and the first idle cycle.
  task automatic frame_check(input logic [7:0] data, input int sb, input logic exp_owner,
                             input int chg_at, input logic [7:0] new_data);
    int   last;
    int   p;
    logic e;
    last = (9 + sb) * 4;
    for (int k = 1; k <= last; k++) begin
      step();
      if (k == chg_at) d0 = new_data;
      p = (k - 1) / 4;
      if (p == 0)      e = 1'b0;
      else if (p <= 8) e = data[p-1];
      else             e = 1'b1;
      check("tx", tx_s, e);
      check("busy", busy_s, 1'b1);
      check("frame_done", done_s, k == last);
      check("owner", owner_s, exp_owner);
      check("ready0_busy", r0_s, 1'b0);
      check("ready1_busy", r1_s, 1'b0);
    end
    step();
    check("idle_busy", busy_s, 1'b0);
    check("idle_tx", tx_s, 1'b1);
    check("idle_done", done_s, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, and readys forced low while reset is high.
    step(); step();
    v0 = 1'b1; v1 = 1'b1;
    #1;
    check("rst_tx", tx_s, 1'b1);
    check("rst_busy", busy_s, 1'b0);
    check("rst_owner", owner_s, 1'b1);
    check("rst_done", done_s, 1'b0);
    check("rst_ready0", r0_s, 1'b0);
    check("rst_ready1", r1_s, 1'b0);

    // req0 sends 0xA5 in the first cycle after reset.
    step();
    reset = 1'b0; v1 = 1'b0; d0 = 8'hA5;
    #1;
    check("a5_ready0", r0_s, 1'b1);
    check("a5_ready1", r1_s, 1'b0);
    frame_check(8'hA5, 1, 1'b0, 0, 8'h00);
    v0 = 1'b0;
    #1;
    check("a5_after_ready0", r0_s, 1'b0);

    // Data changed mid-frame: frame carries 0x3C, next grant carries 0xC3.
    step();
    v0 = 1'b1; d0 = 8'h3C;
    #1;
    check("3c_ready0", r0_s, 1'b1);
    frame_check(8'h3C, 1, 1'b0, 10, 8'hC3);
    #1;
    check("c3_ready0", r0_s, 1'b1);
    frame_check(8'hC3, 1, 1'b0, 0, 8'h00);
    v0 = 1'b0;

    // Reset at T+10 of a 0xFF frame abandons it without frame_done.
    step();
    v0 = 1'b1; d0 = 8'hFF;
    #1;
    check("ff_ready0", r0_s, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) v0 = 1'b0;
      check("ff_tx", tx_s, (k <= 4) ? 1'b0 : 1'b1);
      if (k == 10) reset = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      step();
      check("ffrst_tx", tx_s, 1'b1);
      check("ffrst_busy", busy_s, 1'b0);
      check("ffrst_done", done_s, 1'b0);
      check("ffrst_owner", owner_s, 1'b1);
    end
    v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22;

    // After release with both valid, req0 wins first, then grants alternate.
    step();
    reset = 1'b0;
    #1;
    check("rr0_ready0", r0_s, 1'b1);
    check("rr0_ready1", r1_s, 1'b0);
    frame_check(8'h11, 1, 1'b0, 0, 8'h00);
    #1;
    check("rr1_ready1", r1_s, 1'b1);
    check("rr1_ready0", r0_s, 1'b0);
    frame_check(8'h22, 1, 1'b1, 0, 8'h00);
    #1;
    check("rr2_ready0", r0_s, 1'b1);
    check("rr2_ready1", r1_s, 1'b0);
    frame_check(8'h11, 1, 1'b0, 0, 8'h00);
    #1;
    check("rr3_ready1", r1_s, 1'b1);
    check("rr3_ready0", r0_s, 1'b0);
    frame_check(8'h22, 1, 1'b1, 0, 8'h00);
    v0 = 1'b0; v1 = 1'b0;

    // Two stop bits: req1 sends 0x00 on the second instance.
    step();
    sel = 1'b1; v1 = 1'b1; d1 = 8'h00;
    #1;
    check("sb2_ready1", r1_s, 1'b1);
    check("sb2_ready0", r0_s, 1'b0);
    frame_check(8'h00, 2, 1'b1, 0, 8'h00);
    v1 = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
